// File: rtl/instruction_decode_16bit.sv
// Decode stage: accepts fetched instructions, decodes them at enqueue into a small FIFO,
// and presents the head entry to execute. Optional trap on opcodes 9-14 via ILLEGAL_OPCODE_TRAP_EN.
module instruction_decode_16bit #(
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16:1]       in_instr,
    input  logic [ADDR_W:1]   in_pc,
    input  logic              flush,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [4:1]        dec_opcode,
    output logic [3:1]        dec_rd,
    output logic [3:1]        dec_rs,
    output logic [3:1]        dec_rt,
    output logic [3:1]        dec_funct,
    output logic [16:1]       dec_imm,
    output logic [ADDR_W:1]   dec_pc,
    output logic              dec_writes_reg,
    output logic              halted,
    output logic [16:1]       instr_count
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic              illegal
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

    localparam logic [4:1] OP_ADD  = 4'd0;
    localparam logic [4:1] OP_SUB  = 4'd1;
    localparam logic [4:1] OP_AND  = 4'd2;
    localparam logic [4:1] OP_OR   = 4'd3;
    localparam logic [4:1] OP_ADDI = 4'd4;
    localparam logic [4:1] OP_LW   = 4'd5;
    localparam logic [4:1] OP_SW   = 4'd6;
    localparam logic [4:1] OP_BEQ  = 4'd7;
    localparam logic [4:1] OP_JMP  = 4'd8;
    localparam logic [4:1] OP_HALT = 4'd15;

    typedef struct packed {
        logic [4:1]      opcode;
        logic [3:1]      rd;
        logic [3:1]      rs;
        logic [3:1]      rt;
        logic [3:1]      funct;
        logic [16:1]     imm;
        logic [ADDR_W:1] pc;
        logic            writes_reg;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        logic            illegal;
`endif
    } entry_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t             state;
    state_t             state_next;
    entry_t             mem [BUF_DEPTH];
    entry_t             decoded;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               halting_instr;

    // Decoding happens on the way in, so the FIFO holds ready-to-use fields.
    always_comb begin
        decoded            = '0;
        decoded.opcode     = in_instr[16:13];
        decoded.rd         = in_instr[12:10];
        decoded.rs         = in_instr[9:7];
        decoded.rt         = in_instr[6:4];
        decoded.funct      = in_instr[3:1];
        decoded.pc         = in_pc;
        case (in_instr[16:13])
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                decoded.writes_reg = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                decoded.writes_reg = 1'b1;
                decoded.imm        = {{10{in_instr[6]}}, in_instr[6:1]};
            end
            OP_SW, OP_BEQ: begin
                decoded.imm        = {{10{in_instr[6]}}, in_instr[6:1]};
            end
            OP_JMP: begin
                decoded.imm        = {{4{in_instr[12]}}, in_instr[12:1]};
            end
            OP_HALT: begin
                decoded.writes_reg = 1'b0;
            end
            default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                decoded.illegal    = 1'b1;
`endif
            end
        endcase
    end

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign halting_instr = (in_instr[16:13] == OP_HALT) || decoded.illegal;
`else
    assign halting_instr = (in_instr[16:13] == OP_HALT);
`endif

    assign halted    = (state == ST_HALTED);
    assign in_ready  = (count < FULL_COUNT) && !halted;
    assign dec_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = dec_valid && dec_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Halting entry is still enqueued; only flush or reset returns to RUN.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_RUN;
        end else if (push && halting_instr) begin
            state_next = ST_HALTED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (pop) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    // Outputs read as zero whenever nothing is buffered.
    assign head = dec_valid ? mem[rd_ptr] : '0;

    assign dec_opcode     = head.opcode;
    assign dec_rd         = head.rd;
    assign dec_rs         = head.rs;
    assign dec_rt         = head.rt;
    assign dec_funct      = head.funct;
    assign dec_imm        = head.imm;
    assign dec_pc         = head.pc;
    assign dec_writes_reg = head.writes_reg;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign illegal        = head.illegal;
`endif

endmodule

// File: tb/tb_instruction_decode_16bit.sv
// Directed self-checking bench for instruction_decode_16bit; inputs change and outputs are
// sampled on the falling clock edge.
module tb_instruction_decode_16bit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:1] in_instr;
    logic [16:1] in_pc;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:1]  dec_opcode;
    logic [3:1]  dec_rd;
    logic [3:1]  dec_rs;
    logic [3:1]  dec_rt;
    logic [3:1]  dec_funct;
    logic [16:1] dec_imm;
    logic [16:1] dec_pc;
    logic        dec_writes_reg;
    logic        halted;
    logic [16:1] instr_count;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic        illegal;
`endif

    int compared   = 0;
    int mismatched = 0;

    instruction_decode_16bit #(
        .ADDR_W   (16),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_opcode    (dec_opcode),
        .dec_rd        (dec_rd),
        .dec_rs        (dec_rs),
        .dec_rt        (dec_rt),
        .dec_funct     (dec_funct),
        .dec_imm       (dec_imm),
        .dec_pc        (dec_pc),
        .dec_writes_reg(dec_writes_reg),
        .halted        (halted),
        .instr_count   (instr_count)
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ,
        .illegal       (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic apply_stimulus(input logic v, input logic [16:1] instr, input logic [16:1] pc,
                                  input logic ready, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        dec_ready = ready;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        dec_ready = 1'b0;

        // Reset held for three cycles, released on a falling edge.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_output("rst_dec_valid",   32'(dec_valid), 32'h0);
        check_output("rst_in_ready",    32'(in_ready), 32'h1);
        check_output("rst_halted",      32'(halted), 32'h0);
        check_output("rst_instr_count", 32'(instr_count), 32'h0);
        check_output("rst_opcode",      32'(dec_opcode), 32'h0);
        check_output("rst_imm",         32'(dec_imm), 32'h0);
        check_output("rst_pc",          32'(dec_pc), 32'h0);
        check_output("rst_writes_reg",  32'(dec_writes_reg), 32'h0);

        // Single ADD, visible one edge after acceptance, then popped.
        apply_stimulus(1'b1, 16'h0688, 16'h0010, 1'b1, 1'b0);
        check_output("add_valid",  32'(dec_valid), 32'h1);
        check_output("add_opcode", 32'(dec_opcode), 32'h0);
        check_output("add_rd",     32'(dec_rd), 32'h3);
        check_output("add_rs",     32'(dec_rs), 32'h2);
        check_output("add_rt",     32'(dec_rt), 32'h1);
        check_output("add_funct",  32'(dec_funct), 32'h0);
        check_output("add_wr",     32'(dec_writes_reg), 32'h1);
        check_output("add_pc",     32'(dec_pc), 32'h0010);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check_output("add_drained", 32'(dec_valid), 32'h0);
        check_output("add_count",   32'(instr_count), 32'h1);

        // ADDI with negative immediate, then JMP pushed while ADDI pops.
        apply_stimulus(1'b1, 16'h427E, 16'h0020, 1'b1, 1'b0);
        check_output("addi_opcode", 32'(dec_opcode), 32'h4);
        check_output("addi_rd",     32'(dec_rd), 32'h1);
        check_output("addi_rs",     32'(dec_rs), 32'h1);
        check_output("addi_imm",    32'(dec_imm), 32'hFFFE);
        check_output("addi_wr",     32'(dec_writes_reg), 32'h1);
        apply_stimulus(1'b1, 16'h8FFF, 16'h0030, 1'b1, 1'b0);
        check_output("jmp_valid",  32'(dec_valid), 32'h1);
        check_output("jmp_opcode", 32'(dec_opcode), 32'h8);
        check_output("jmp_imm",    32'(dec_imm), 32'hFFFF);
        check_output("jmp_wr",     32'(dec_writes_reg), 32'h0);
        check_output("jmp_pc",     32'(dec_pc), 32'h0030);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check_output("jmp_drained", 32'(dec_valid), 32'h0);
        check_output("jmp_count",   32'(instr_count), 32'h3);

        // Backpressure: two fill the buffer, third waits for space.
        apply_stimulus(1'b1, 16'h0688, 16'h0100, 1'b0, 1'b0);
        check_output("bp_ready_1", 32'(in_ready), 32'h1);
        apply_stimulus(1'b1, 16'h427E, 16'h0102, 1'b0, 1'b0);
        check_output("bp_full_ready", 32'(in_ready), 32'h0);
        check_output("bp_head_pc",    32'(dec_pc), 32'h0100);
        apply_stimulus(1'b1, 16'h8FFF, 16'h0104, 1'b0, 1'b0);
        check_output("bp_hold_pc",     32'(dec_pc), 32'h0100);
        check_output("bp_hold_opcode", 32'(dec_opcode), 32'h0);
        check_output("bp_hold_ready",  32'(in_ready), 32'h0);
        apply_stimulus(1'b1, 16'h8FFF, 16'h0104, 1'b1, 1'b0);
        check_output("bp_second_pc",     32'(dec_pc), 32'h0102);
        check_output("bp_second_opcode", 32'(dec_opcode), 32'h4);
        check_output("bp_space_ready",   32'(in_ready), 32'h1);
        apply_stimulus(1'b1, 16'h8FFF, 16'h0104, 1'b1, 1'b0);
        check_output("bp_third_pc",     32'(dec_pc), 32'h0104);
        check_output("bp_third_opcode", 32'(dec_opcode), 32'h8);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check_output("bp_drained", 32'(dec_valid), 32'h0);
        check_output("bp_count",   32'(instr_count), 32'h6);

        // HALT freezes intake; the HALT entry itself still drains; flush releases.
        apply_stimulus(1'b1, 16'hF000, 16'h0200, 1'b0, 1'b0);
        check_output("halt_halted", 32'(halted), 32'h1);
        check_output("halt_ready",  32'(in_ready), 32'h0);
        check_output("halt_opcode", 32'(dec_opcode), 32'hF);
        check_output("halt_wr",     32'(dec_writes_reg), 32'h0);
        apply_stimulus(1'b1, 16'h0688, 16'h0202, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check_output("halt_not_taken", 32'(dec_valid), 32'h0);
        check_output("halt_still",     32'(halted), 32'h1);
        check_output("halt_count",     32'(instr_count), 32'h7);
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check_output("unhalt_halted", 32'(halted), 32'h0);
        check_output("unhalt_ready",  32'(in_ready), 32'h1);

        // Flush with a full buffer and a pending push.
        apply_stimulus(1'b1, 16'h0688, 16'h0300, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h427E, 16'h0302, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h8FFF, 16'h0304, 1'b0, 1'b1);
        check_output("flush_full_valid", 32'(dec_valid), 32'h0);
        check_output("flush_full_ready", 32'(in_ready), 32'h1);

        // Flush beats a same-cycle push and pop; count untouched.
        apply_stimulus(1'b1, 16'h0688, 16'h0310, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h427E, 16'h0312, 1'b1, 1'b1);
        check_output("flush_pop_valid", 32'(dec_valid), 32'h0);
        check_output("flush_pop_count", 32'(instr_count), 32'h7);

        // Reserved opcode 9.
        apply_stimulus(1'b1, 16'h9000, 16'h0400, 1'b0, 1'b0);
        check_output("rsv_opcode", 32'(dec_opcode), 32'h9);
        check_output("rsv_wr",     32'(dec_writes_reg), 32'h0);
        check_output("rsv_imm",    32'(dec_imm), 32'h0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
        check_output("rsv_illegal", 32'(illegal), 32'h1);
        check_output("rsv_halted",  32'(halted), 32'h1);
`else
        check_output("rsv_halted",  32'(halted), 32'h0);
`endif
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check_output("rsv_count", 32'(instr_count), 32'h8);

        // Asynchronous reset mid-operation drops buffered entries immediately.
        apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h0688, 16'h0500, 1'b0, 1'b0);
        check_output("pre_reset_valid", 32'(dec_valid), 32'h1);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_output("async_valid", 32'(dec_valid), 32'h0);
        check_output("async_count", 32'(instr_count), 32'h0);
        check_output("async_pc",    32'(dec_pc), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        check_output("post_reset_ready", 32'(in_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
